// File: rtl/icache_if.sv
// Fetch-side and memory-side signal bundle for the instruction cache.
// slave is the cache; master is the IF stage plus mem_ctrl side.
interface icache_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        if_busy;
    logic        if_valid;
    logic [31:0] if_inst;
    logic        mc_req;
    logic [31:0] mc_addr;
    logic        mc_done;
    logic [31:0] mc_data;

    modport slave (
        input  if_req, if_addr, if_flush, mc_done, mc_data,
        output if_busy, if_valid, if_inst, mc_req, mc_addr
    );

    modport master (
        output if_req, if_addr, if_flush, mc_done, mc_data,
        input  if_busy, if_valid, if_inst, mc_req, mc_addr
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache, one 32-bit word per line.
// Misses become a single word read on mem_ctrl; I/O space bypasses the arrays.
module icache #(
    parameter int INDEX_W   = 8,
    parameter int ADDR_USED = 18
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     rdy_i,
    icache_if.slave  bus
);
    localparam int TAG_W = ADDR_USED - 2 - INDEX_W;
    localparam int LINES = 2 ** INDEX_W;

    typedef enum logic [1:0] {
        IDLE, LOOKUP, MISS, RESP
    } state_e;

    state_e           state_q;
    logic [29:0]      addr_q;
    logic             abort_q;
    logic             busy_q;
    logic             valid_q;
    logic [31:0]      inst_q;
    logic             mc_req_q;
    logic [31:0]      mc_addr_q;
    logic [LINES-1:0] vld_q;

    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic               io;
    logic               hit;
    logic               fill;
    logic               unused_lsb;

    // addr_q holds the word address, so byte bit n sits at n-2
    assign idx  = addr_q[INDEX_W-1:0];
    assign tag  = addr_q[ADDR_USED-3:INDEX_W];
    assign io   = addr_q[ADDR_USED-3 -: 2] == 2'b11;
    assign hit  = vld_q[idx] && (tag_mem[idx] == tag) && !io;
    assign fill = rdy_i && (state_q == MISS) && bus.mc_done && !io;

    assign unused_lsb = ^bus.if_addr[1:0];

    assign bus.if_busy  = busy_q;
    assign bus.if_valid = valid_q;
    assign bus.if_inst  = inst_q;
    assign bus.mc_req   = mc_req_q;
    assign bus.mc_addr  = mc_addr_q;

    always_ff @(posedge clk_i) begin
        if (fill) begin
            tag_mem[idx]  <= tag;
            data_mem[idx] <= bus.mc_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            abort_q   <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            inst_q    <= '0;
            mc_req_q  <= 1'b0;
            mc_addr_q <= '0;
            vld_q     <= '0;
        end else if (rdy_i) begin
            unique case (state_q)
                IDLE, RESP: begin
                    valid_q <= 1'b0;
                    if (bus.if_req && !bus.if_flush) begin
                        addr_q  <= bus.if_addr[31:2];
                        abort_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= LOOKUP;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                LOOKUP: begin
                    if (bus.if_flush) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (hit) begin
                        inst_q  <= data_mem[idx];
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= RESP;
                    end else begin
                        mc_req_q  <= 1'b1;
                        mc_addr_q <= {addr_q, 2'b00};
                        state_q   <= MISS;
                    end
                end
                MISS: begin
                    if (bus.mc_done) begin
                        mc_req_q <= 1'b0;
                        busy_q   <= 1'b0;
                        abort_q  <= 1'b0;
                        if (!io) begin
                            vld_q[idx] <= 1'b1;
                        end
                        // a flush landing with mc_done still abandons the fetch
                        if (abort_q || bus.if_flush) begin
                            state_q <= IDLE;
                        end else begin
                            inst_q  <= bus.mc_data;
                            valid_q <= 1'b1;
                            state_q <= RESP;
                        end
                    end else if (bus.if_flush) begin
                        abort_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_icache.sv
// Randomized scoreboard bench for icache against a line-level cache model.
// A monitor pops expected words whenever if_valid is seen.
module tb_icache;
    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic rdy = 1'b1;

    icache_if bus();

    icache dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .rdy_i  (rdy),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] inst;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    logic        m_vld [256];
    logic [7:0]  m_tag [256];
    logic [31:0] m_dat [256];
    int unsigned epoch = 0;
    logic [31:0] last_inst;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    // Backing memory: word contents change whenever epoch moves on.
    function automatic logic [31:0] mem(input logic [31:0] a);
        logic [31:0] w;
        w = {2'b00, a[31:2]};
        if (w == 32'h40 && epoch == 0) return 32'h00A0_0093;
        return (w * 32'h9E37_79B1) ^ (epoch * 32'h85EB_CA6B) ^ 32'h1234_5678;
    endfunction

    task automatic push(input logic [31:0] inst, input int c);
        exp_t e;
        e.inst = inst;
        e.cyc  = c;
        q.push_back(e);
    endtask

    always @(negedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            last_inst = '0;
        end else if (bus.if_valid) begin
            if (q.size() == 0) begin
                chk("spurious_valid", 32'd1, 32'd0);
            end else begin
                mon_e = q.pop_front();
                chk("inst", bus.if_inst, mon_e.inst);
                chk("latency", cyc, mon_e.cyc);
            end
            last_inst = bus.if_inst;
        end else begin
            chk("inst_hold", bus.if_inst, last_inst);
        end
    end

    // fmode: 0 plain, 1 flush in LOOKUP, 2 flush in MISS at fk,
    // 3 rdy low for 3 cycles with mc_done held, 4 reset mid-MISS,
    // 5 flush together with if_req.
    task automatic fetch(input logic [31:0] a, input int fmode,
                         input int lat, input int fk);
        logic [7:0]  idx;
        logic [7:0]  tg;
        logic        io;
        logic        hit;
        logic [31:0] d;
        bit          ab;
        int          c0;
        idx = a[9:2];
        tg  = a[17:10];
        io  = (a[17:16] == 2'b11);
        hit = m_vld[idx] && (m_tag[idx] == tg) && !io;
        ab  = 1'b0;
        c0  = cyc;
        bus.if_req  = 1'b1;
        bus.if_addr = a;
        if (fmode == 5) begin
            bus.if_flush = 1'b1;
            @(negedge clk);
            bus.if_req   = 1'b0;
            bus.if_flush = 1'b0;
            chk("flush_req_busy", {31'd0, bus.if_busy}, 32'd0);
            return;
        end
        @(negedge clk);
        bus.if_req = 1'b0;
        if (fmode == 1) begin
            bus.if_flush = 1'b1;
            @(negedge clk);
            bus.if_flush = 1'b0;
            chk("flush_lookup", {30'd0, bus.if_busy, bus.mc_req}, 32'd0);
            return;
        end
        chk("lookup_busy", {31'd0, bus.if_busy}, 32'd1);
        if (hit) begin
            push(m_dat[idx], c0 + 2);
            @(negedge clk);
            chk("hit_no_mcreq", {31'd0, bus.mc_req}, 32'd0);
            return;
        end
        @(negedge clk);
        chk("miss_req", {31'd0, bus.mc_req}, 32'd1);
        chk("miss_addr", bus.mc_addr, {a[31:2], 2'b00});
        d = mem(a);
        if (fmode == 4) begin
            repeat (fk) @(negedge clk);
            rst_ni = 1'b0;
            #1;
            chk("rst_mcreq", {31'd0, bus.mc_req}, 32'd0);
            chk("rst_busy", {31'd0, bus.if_busy}, 32'd0);
            chk("rst_inst", bus.if_inst, 32'd0);
            for (int i = 0; i < 256; i++) m_vld[i] = 1'b0;
            @(negedge clk);
            rst_ni = 1'b1;
            return;
        end
        if (fmode == 3) begin
            repeat (fk) @(negedge clk);
            rdy         = 1'b0;
            bus.mc_done = 1'b1;
            bus.mc_data = d;
            repeat (3) begin
                @(negedge clk);
                chk("rdy_mcreq", {31'd0, bus.mc_req}, 32'd1);
                chk("rdy_mcaddr", bus.mc_addr, {a[31:2], 2'b00});
                chk("rdy_busy", {31'd0, bus.if_busy}, 32'd1);
            end
            rdy = 1'b1;
        end else begin
            for (int i = 0; i < lat; i++) begin
                if (fmode == 2 && i == fk) begin
                    bus.if_flush = 1'b1;
                    ab = 1'b1;
                end
                @(negedge clk);
                bus.if_flush = 1'b0;
            end
            bus.mc_done = 1'b1;
            bus.mc_data = d;
        end
        if (!ab) push(d, cyc + 1);
        if (!io) begin
            m_vld[idx] = 1'b1;
            m_tag[idx] = tg;
            m_dat[idx] = d;
        end
        @(negedge clk);
        bus.mc_done = 1'b0;
        bus.mc_data = $urandom;
        chk("miss_drop", {31'd0, bus.mc_req}, 32'd0);
    endtask

    task automatic gap(input int n, input bit noise);
        for (int i = 0; i < n; i++) begin
            bus.mc_done = noise && ($urandom_range(0, 3) == 0);
            bus.mc_data = $urandom;
            @(negedge clk);
        end
        bus.mc_done = 1'b0;
    endtask

    initial begin
        int          r;
        int          mode;
        int          lat;
        int          fk;
        logic [31:0] a;
        logic [7:0]  tg;
        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.if_flush = 1'b0;
        bus.mc_done  = 1'b0;
        bus.mc_data  = '0;
        for (int i = 0; i < 256; i++) m_vld[i] = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'd0, bus.if_busy}, 32'd0);
        chk("reset_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("reset_inst", bus.if_inst, 32'd0);
        chk("reset_mcreq", {31'd0, bus.mc_req}, 32'd0);
        chk("reset_mcaddr", bus.mc_addr, 32'd0);
        rst_ni = 1'b1;
        @(negedge clk);

        fetch(32'h0000_0100, 0, 6, 0);
        gap(2, 1'b0);
        fetch(32'h0000_0100, 0, 3, 0);
        gap(1, 1'b0);
        fetch(32'h0000_0500, 0, 3, 0);
        fetch(32'h0000_0100, 0, 4, 0);
        gap(1, 1'b0);
        fetch(32'h0000_0500, 0, 3, 0);
        fetch(32'h0000_0100, 2, 5, 2);
        gap(1, 1'b0);
        fetch(32'h0000_0100, 0, 3, 0);
        fetch(32'h0000_0000, 0, 2, 0);
        fetch(32'h0003_0000, 0, 3, 0);
        fetch(32'h0003_0000, 0, 2, 0);
        fetch(32'h0000_0000, 0, 2, 0);
        gap(1, 1'b1);
        fetch(32'h0000_0900, 3, 4, 1);
        fetch(32'h0000_0900, 0, 2, 0);
        fetch(32'h0000_0D00, 4, 4, 2);
        fetch(32'h0000_0900, 0, 2, 0);
        fetch(32'h0000_0100, 5, 1, 0);
        fetch(32'h0000_0100, 1, 1, 0);

        for (int n = 0; n < 300; n++) begin
            gap($urandom_range(0, 2), 1'b1);
            if ($urandom_range(0, 19) == 0) epoch++;
            r = $urandom_range(0, 3);
            tg = (r == 3) ? 8'hC0 : 8'(r);
            a = {($urandom_range(0, 7) == 0) ? 14'($urandom) : 14'd0,
                 tg, 6'd0, 2'($urandom_range(0, 3)), 2'($urandom)};
            r = $urandom_range(0, 39);
            mode = (r < 2) ? 1 : (r < 4) ? 2 : (r < 6) ? 3 :
                   (r < 8) ? 5 : (r == 8) ? 4 : 0;
            lat = $urandom_range(1, 6);
            fk = $urandom_range(0, lat - 1);
            fetch(a, mode, lat, fk);
        end

        gap(5, 1'b0);
        chk("drain", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
